// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier.
package seq_shift_add_mult_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Ceiling log2, used to size the bit counter
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_shift_add_mult_shift_add_step.sv
// One iteration of shift-and-add: folds partial product bit i into the accumulator.
module shift_add_step
  import seq_shift_add_mult_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [2*N-1:0]        acc_i,
  input  logic [2*N-1:0]        a_ext_i,
  input  logic [clog2(N)-1:0]   bit_idx_i,
  input  logic                  b_bit_i,
  input  logic                  signed_i,
  input  logic                  last_i,
  output logic [2*N-1:0]        acc_o
);

  localparam int unsigned W = 2 * N;

  logic [W-1:0] term;

  // Shifted multiplicand; in signed mode the top multiplier bit has negative weight
  always_comb begin
    term  = a_ext_i << bit_idx_i;
    acc_o = acc_i;
    if (b_bit_i) begin
      if (signed_i && last_i) begin
        acc_o = acc_i - term;
      end else begin
        acc_o = acc_i + term;
      end
    end
  end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative N-bit multiplier: one multiplier bit per clock, start/ready/done handshake.
module seq_shift_add_mult
  import seq_shift_add_mult_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned SIGNED_SUPPORT = 1
) (
  input  logic           clk,
  input  logic           stop,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] AQ
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = clog2(N);

  logic [0:0]    state_q, state_d;
  logic          ready_q, ready_d;
  logic          done_q,  done_d;
  logic [W-1:0]  aq_q,    aq_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]  a_ext_q, a_ext_d;
  logic [N-1:0]  b_q,     b_d;
  logic          mode_q,  mode_d;

  logic [W-1:0]  acc_step;
  logic          last_bit;
  logic          mode_in;

  assign last_bit = (cnt_q == CW'(N - 1));
  assign mode_in  = signed_mode & (SIGNED_SUPPORT != 0);

  shift_add_step #(.N(N)) u_step (
    .acc_i     (acc_q),
    .a_ext_i   (a_ext_q),
    .bit_idx_i (cnt_q),
    .b_bit_i   (b_q[cnt_q]),
    .signed_i  (mode_q),
    .last_i    (last_bit),
    .acc_o     (acc_step)
  );

  // State and datapath registers; stop is a synchronous reset with priority
  always_ff @(posedge clk) begin
    if (stop) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      aq_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      a_ext_q <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      aq_q    <= aq_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      a_ext_q <= a_ext_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic: capture on start, iterate one bit per cycle, publish on last bit
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    aq_d    = aq_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    a_ext_d = a_ext_q;
    b_d     = b_q;
    mode_d  = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ready_d = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          b_d     = B;
          mode_d  = mode_in;
          a_ext_d = mode_in ? {{N{A[N-1]}}, A} : {{N{1'b0}}, A};
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        if (last_bit) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
          aq_d    = acc_step;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign AQ    = aq_q;

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Iterative, parametrised successor to the single-cycle shift-and-add multiplier.
- Processes one multiplier bit per clock, so an N-bit multiply takes N cycles with a single 2N-bit adder instead of N chained adders.
- Adds a start/ready/done handshake, a selectable two's-complement mode and a held result register.
- Sits in the arithmetic datapath as a drop-in multiply engine for any controller that can tolerate N-cycle latency.

Parameters:
- N, 8, operand width in bits (N >= 2); result width is 2N.
- SIGNED_SUPPORT, 1, when 0 the signed_mode input is ignored and all operations are unsigned.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- stop  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on a rising edge where ready=1.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A  input  N  multiplicand; sampled with start.
- B  input  N  multiplier; sampled with start.
- ready  output  1  high when a new start will be accepted.
- done  output  1  one-cycle pulse when AQ has just been updated.
- AQ  output  2N  product; held until the next completion.

Behaviour:
- Reset: stop=1 at a rising edge forces state IDLE, AQ=0, done=0, ready=1, accumulator=0, bit counter=0.
  - Synchronous only: stop has no effect between edges.
  - stop has priority over start.
- States:
  - IDLE: ready=1.
  - RUN: ready=0.
- IDLE -> RUN on an edge with start=1 and stop=0. At that edge the block captures A, B and mode (signed_mode AND SIGNED_SUPPORT), clears the accumulator to 0 and sets the counter to 0.
- RUN, every edge, with i = counter:
  - If B[i]=1, accumulator += (A_ext << i), computed modulo 2^2N.
  - A_ext is A zero-extended to 2N bits (unsigned mode) or sign-extended to 2N bits (signed mode).
  - Signed mode with i = N-1: the term is subtracted instead of added (weight -2^(N-1)).
  - If B[i]=0, the accumulator is unchanged.
  - Counter increments by 1.
- RUN -> IDLE on the edge processing i = N-1. On that same edge:
  - AQ <= final accumulator value.
  - done <= 1.
  - ready becomes 1.
- done is high for exactly one cycle, then returns to 0.
- Latency: start accepted at edge k gives done=1 and a valid AQ after edge k+N.
- Back-to-back: start=1 during the done cycle is accepted. Throughput is one result per N cycles.
- start while ready=0 is ignored; no queuing, no error flag.
- Changes on A, B and signed_mode during RUN are ignored.
- AQ is not cleared when a new operation starts; it changes only at completion or reset.
- stop=1 during RUN aborts the operation: no done pulse, AQ=0.
- Result is exact in 2N bits; there is no overflow condition.
- Counter width is clog2(N), with no wrap beyond N-1.

Decomposition:
- Shared arithmetic package holds:
  - state encoding localparams: ST_IDLE=0, ST_RUN=1;
  - the counter-width function (clog2).
- One natural sub-module: shift_add_step. It is purely combinational and computes the next accumulator value from the current accumulator, A_ext, bit i, B[i], mode and the last-bit flag.
- The top level holds the FSM, the operand registers and AQ.

Test Plan:
- Reset: stop=1 for 2 cycles with start=1 -> AQ=0x0000, done=0, ready=1; no operation starts.
- Unsigned, N=8: A=0xFF, B=0xFF, signed_mode=0, start=1 -> ready=0 for 8 cycles, then done pulses once with AQ=0xFE01; AQ still 0xFE01 two cycles later.
- Signed, N=8:
  - A=0x7F, B=0x80 -> AQ=0xC080 (-16256).
  - A=0x80, B=0x80 -> AQ=0x4000.
  - A=0xFF, B=0xFF -> AQ=0x0001.
  - Each result appears exactly 8 cycles after acceptance.
- Handshake:
  - Pulse start at cycle 3 of RUN with A=0x02, B=0x03 -> ignored; the original result completes unchanged.
  - Then assert start during the done cycle with A=0x0A, B=0x0C, unsigned -> accepted; AQ=0x0078 after 8 more edges.
- Abort: start A=0x10, B=0x10, then stop=1 at cycle 4 of RUN -> AQ=0, no done pulse, ready=1 on the next cycle.
- SIGNED_SUPPORT=0 build: A=0x80, B=0x80, signed_mode=1 -> AQ=0x4000 (unsigned 128*128). Repeat with N=4: A=0xF, B=0xF -> AQ=0xE1 after 4 cycles.
